dmem_responder: RTL and testbench

- Memory-side responder for the processor data port: accepts word-addressed read/write requests over a req/ack handshake and serves them from an internal word array after a programmable number of wait states.
- Replaces the single-cycle data cache as the data-port target when multi-cycle memory timing is modelled.
- Byte lane selection arrives as byte enables; sign/zero extension of loaded data remains a processor-side job.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-port memory target: word array behind a req/ack handshake with
// WAIT_CYCLES wait states, byte-enable writes and out-of-range error reporting.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [2**DEPTH_LOG2];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic        do_access;
  logic [29:0] acc_addr;
  logic        acc_rw;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        in_range;
  logic        mem_we;

  // With zero wait states the access happens on the capture edge itself,
  // so the live inputs are used instead of the not-yet-loaded captures.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = addr;
      acc_rw    = rw;
      acc_wdata = wdata;
      acc_be    = be;
    end else begin
      acc_addr  = addr_q;
      acc_rw    = rw_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign in_range = (acc_addr[29:DEPTH_LOG2] == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    ack_d     = ack_q;
    err_d     = err_q;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        addr_d  = addr;
        rw_d    = rw;
        wdata_d = wdata;
        be_d    = be;
        if (WAIT_CYCLES > 0) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          do_access = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               do_access = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_access) begin
      state_d = S_RESP;
      ack_d   = 1'b1;
      err_d   = !in_range;
      rdata_d = (in_range && !acc_rw) ? mem[acc_addr[DEPTH_LOG2-1:0]] : '0;
    end
  end

  assign mem_we = do_access && acc_rw && in_range && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately not reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (acc_be[i]) mem[acc_addr[DEPTH_LOG2-1:0]][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes model-predicted responses,
// a negedge monitor pops and checks data, error, ack timing and pulse width.
module tb_dmem_responder;
  localparam int DL = 10;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, rw;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack, err, busy;

  logic        req0;
  logic [31:0] rdata0;
  logic        ack0, err0, busy0;

  dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .ack(ack), .err(err), .busy(busy));

  dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .rw(1'b0), .addr(30'd0), .wdata(32'd0),
    .be(4'd0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl[int];
  int          total = 0;
  int          bad   = 0;
  bit          done  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: memory as a map of words; byte-lane merge done per lane.
  task automatic issue(input logic w, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] b, input int cap);
    exp_t e;
    logic [31:0] old;
    req = 1'b1; rw = w; addr = a; wdata = d; be = b;
    e.at = cap + WC;
    if ((a >> DL) != 0) begin
      e.rdata = '0; e.err = 1'b1;
    end else if (w) begin
      old = mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (b[i]) old[8*i +: 8] = d[8*i +: 8];
      mdl[int'(a)] = old;
      e.rdata = '0; e.err = 1'b0;
    end else begin
      e.rdata = mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
      e.err = 1'b0;
    end
    sbq.push_back(e);
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 50);
    if (!ack) begin
      total++; bad++;
      $display("FAIL ack_timeout got=0 want=1 (cyc %0d)", cyc);
    end
  endtask

  task automatic txn(input logic w, input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
    issue(w, a, d, b, cyc + 1);
    wait_ack();
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit prev_ack = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done && !reset && ack) begin
        if (prev_ack) begin
          total++; bad++;
          $display("FAIL ack_width got=2+ want=1 (cyc %0d)", cyc);
        end
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack got=1 want=0 (cyc %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("ack_cycle", cyc, e.at);
          chk("busy_in_resp", {31'd0, busy}, 32'd1);
        end
      end
      prev_ack = ack;
    end
  end

  initial begin
    bit p;
    logic [29:0] a;
    reset = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; be = '0; req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    txn(1, 30'h5, 32'hDEADBEEF, 4'hF);
    txn(0, 30'h5, 32'h0, 4'h0);
    txn(1, 30'h5, 32'h11223344, 4'b0101);
    txn(0, 30'h5, 32'h0, 4'h0);
    chk("be_merge_model", mdl[5], 32'hDE22BE44);

    txn(1, 30'h0, 32'h01234567, 4'hF);
    txn(0, 30'h400, 32'h0, 4'h0);
    txn(1, 30'h400, 32'hFFFFFFFF, 4'hF);
    txn(0, 30'h0, 32'h0, 4'h0);

    txn(1, 30'h5, 32'hCAFEF00D, 4'hF);
    txn(1, 30'h5, 32'h55555555, 4'h0);
    txn(0, 30'h5, 32'h0, 4'h0);

    // Abort: reset lands just before the access edge; nothing commits.
    txn(1, 30'h7, 32'h0, 4'hF);
    req = 1'b1; rw = 1'b1; addr = 30'h7; wdata = 32'hAAAA5555; be = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("abort_ack", {31'd0, ack}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    txn(0, 30'h7, 32'h0, 4'h0);

    // req dropped in WAIT: still commits and acks.
    issue(1, 30'h9, 32'h87654321, 4'hF, cyc + 1);
    @(negedge clk);
    req = 1'b0; addr = 30'h3FF; wdata = 32'h0;
    wait_ack();
    @(negedge clk);
    txn(0, 30'h9, 32'h0, 4'h0);

    // Back-to-back with req held: next capture two edges after the ack edge.
    issue(1, 30'h2, 32'h0BADF00D, 4'hF, cyc + 1);
    wait_ack();
    issue(0, 30'h2, 32'h0, 4'h0, cyc + 2);
    wait_ack();
    issue(0, 30'h401, 32'h0, 4'h0, cyc + 2);
    wait_ack();
    req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) txn(1, 30'(i), $urandom, 4'hF);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 30'(32'h400 + $urandom_range(0, 4095)) : 30'($urandom_range(0, 7));
      txn(1'($urandom), a, $urandom, 4'($urandom));
    end

    // Zero-wait instance with req held high: ack every other cycle.
    req0 = 1'b1;
    repeat (3) @(negedge clk);
    p = ack0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("wc0_toggle", {31'd0, ack0}, {31'd0, !p});
      chk("wc0_busy", {31'd0, busy0}, {31'd0, ack0});
      p = ack0;
    end
    req0 = 1'b0;

    repeat (5) @(negedge clk);
    done = 1;
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
